// File: rtl/din_packer.sv
`default_nettype none
// ============================================================================
// Module   : din_packer
// Brief    : Packs a byte stream into 8-lane groups with valid/busy handshakes.
//            Optional short-group flush on in_last when PACKER_FLUSH_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module din_packer (
  input  logic       clk,
  input  logic       rst,
  output logic       in_busy,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       out_busy,
  output logic       out_vld,
  output logic [7:0] out_data_a,
  output logic [7:0] out_data_b,
  output logic [7:0] out_data_c,
  output logic [7:0] out_data_d,
  output logic [7:0] out_data_e,
  output logic [7:0] out_data_f,
  output logic [7:0] out_data_g,
  output logic [7:0] out_data_h
);

  logic [2:0] r_idx;
  logic [7:0] r_acc [7];
  logic [7:0] r_out [8];
  logic       r_vld;

  logic [7:0] w_lane [8];
  logic       w_last;
  logic       w_complete;
  logic       w_accept;
  logic       w_load;
  logic       w_xfer;

`ifdef PACKER_FLUSH_EN
  assign w_last = in_last;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign w_last        = 1'b0;
`endif

  // A completing byte can only stall when the output register is still occupied.
  assign w_complete = (r_idx == 3'd7) || w_last;
  assign in_busy    = !rst && w_complete && r_vld && out_busy;
  assign w_accept   = in_vld && !in_busy;
  assign w_load     = w_accept && w_complete;
  assign w_xfer     = r_vld && !out_busy;

  // Lanes below idx come from the accumulator, lane idx takes the live byte,
  // lanes above idx are zero (only reachable on a flushed short group).
  always_comb begin
    for (int j = 0; j < 7; j++) begin
      if (r_idx > 3'(j)) begin
        w_lane[j] = r_acc[j];
      end else if (r_idx == 3'(j)) begin
        w_lane[j] = in_data;
      end else begin
        w_lane[j] = 8'h00;
      end
    end
    w_lane[7] = (r_idx == 3'd7) ? in_data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 3'd0;
      r_vld <= 1'b0;
      for (int j = 0; j < 7; j++) begin
        r_acc[j] <= 8'h00;
      end
      for (int j = 0; j < 8; j++) begin
        r_out[j] <= 8'h00;
      end
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_idx <= 3'd0;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
      for (int j = 0; j < 7; j++) begin
        if (w_accept && !w_complete && (r_idx == 3'(j))) begin
          r_acc[j] <= in_data;
        end
      end
      if (w_load) begin
        for (int j = 0; j < 8; j++) begin
          r_out[j] <= w_lane[j];
        end
        r_vld <= 1'b1;
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign out_vld    = r_vld;
  assign out_data_a = r_out[0];
  assign out_data_b = r_out[1];
  assign out_data_c = r_out[2];
  assign out_data_d = r_out[3];
  assign out_data_e = r_out[4];
  assign out_data_f = r_out[5];
  assign out_data_g = r_out[6];
  assign out_data_h = r_out[7];

endmodule
`default_nettype wire
